// File: rtl/pic16f84_pkg.sv
// Shared types and constants for the PIC16F84 Q-phase decoder.
// Phase encoding, FSM states, fault codes and the clk_out table.
package pic16f84_pkg;

    typedef enum logic [1:0] {
        PH_Q1 = 2'd0,
        PH_Q2 = 2'd1,
        PH_Q3 = 2'd2,
        PH_Q4 = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_ONEHOT = 3'd1;
    localparam logic [2:0] ERR_ORDER  = 3'd2;
    localparam logic [2:0] ERR_CLKOUT = 3'd3;
    localparam logic [2:0] ERR_PWR    = 3'd4;

    // Bit i is the expected clk_out level during phase i (high in Q1,Q2).
    localparam logic [3:0] CLKOUT_TABLE = 4'b0011;

    function automatic logic clk_out_exp(input logic [1:0] ph);
        logic [3:0] tbl;
        tbl = CLKOUT_TABLE;
        return tbl[ph];
    endfunction

endpackage

// File: rtl/pic16f84_q_encode.sv
// One-hot Q-line encoder: {q4,q3,q2,q1} -> {valid, phase}.
// Zero-hot and multi-hot inputs report valid=0.
module pic16f84_q_encode
    import pic16f84_pkg::*;
(
    input  logic [3:0] q,
    output logic       valid,
    output logic [1:0] phase
);

    // Map exactly-one-hot patterns to a phase index.
    always_comb begin
        valid = 1'b1;
        phase = PH_Q1;
        case (q)
            4'b0001: phase = PH_Q1;
            4'b0010: phase = PH_Q2;
            4'b0100: phase = PH_Q3;
            4'b1000: phase = PH_Q4;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/pic16f84_qphase_decoder.sv
// Q-phase sequence decoder: acquires lock on the Q1..Q4 stream,
// counts instruction cycles and reports phase/clk_out/power faults.
module pic16f84_qphase_decoder
    import pic16f84_pkg::*;
#(
    parameter int         LOCK_CYCLES = 2,
    parameter logic [3:0] VDD_MIN     = 4'h4
) (
    input  logic        clk,
    input  logic        mclr,
    input  logic [3:0]  vdd,
    input  logic [3:0]  vss,
    input  logic        q1,
    input  logic        q2,
    input  logic        q3,
    input  logic        q4,
    input  logic        clk_out,
    output logic [1:0]  phase,
    output logic        locked,
    output logic        cycle_strobe,
    output logic [15:0] instr_count,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [7:0]  err_count
);

    localparam int AW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    state_e         state, st_n;
    logic [AW-1:0]  acq_cnt, acq_n;
    logic           trk, trk_n;
    logic [15:0]    instr_q, instr_n;
    logic [1:0]     ph_n;
    logic           strobe_n, err_n, locked_n;
    logic [2:0]     code_n;
    logic [7:0]     cnt_n, cnt_inc;
    logic           enc_valid;
    logic [1:0]     enc_ph, exp_ph;
    logic           pwr_fail, is_q1;

    pic16f84_q_encode u_enc (
        .q     ({q4, q3, q2, q1}),
        .valid (enc_valid),
        .phase (enc_ph)
    );

    assign instr_count = instr_q;
    assign pwr_fail    = (vdd < VDD_MIN) || (vss != 4'h0);
    assign exp_ph      = phase + 2'd1;
    assign is_q1       = enc_valid && (enc_ph == PH_Q1);
    assign cnt_inc     = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

    // Next-state, fault classification and counter updates.
    always_comb begin
        st_n     = state;
        acq_n    = acq_cnt;
        trk_n    = trk;
        instr_n  = instr_q;
        ph_n     = enc_valid ? enc_ph : phase;
        strobe_n = 1'b0;
        err_n    = 1'b0;
        code_n   = err_code;
        cnt_n    = err_count;
        if (pwr_fail) begin
            st_n  = ST_ACQUIRE;
            acq_n = '0;
            trk_n = 1'b0;
            if (state == ST_LOCKED) begin
                err_n  = 1'b1;
                code_n = ERR_PWR;
                cnt_n  = cnt_inc;
            end
        end else begin
            case (state)
                ST_ACQUIRE: begin
                    if (trk && enc_valid && enc_ph == exp_ph) begin
                        if (enc_ph == PH_Q4) begin
                            if (acq_cnt == AW'(LOCK_CYCLES - 1)) begin
                                st_n  = ST_LOCKED;
                                acq_n = '0;
                                trk_n = 1'b0;
                            end else begin
                                acq_n = acq_cnt + AW'(1);
                            end
                        end
                    end else begin
                        trk_n = is_q1;
                        acq_n = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!enc_valid) begin
                        err_n  = 1'b1;
                        code_n = ERR_ONEHOT;
                    end else if (enc_ph != exp_ph) begin
                        err_n  = 1'b1;
                        code_n = ERR_ORDER;
                    end else if (clk_out != clk_out_exp(enc_ph)) begin
                        err_n  = 1'b1;
                        code_n = ERR_CLKOUT;
                    end else if (enc_ph == PH_Q4) begin
                        strobe_n = 1'b1;
                        instr_n  = instr_q + 16'd1;
                    end
                    if (err_n) begin
                        st_n  = ST_FAULT;
                        cnt_n = cnt_inc;
                    end
                end
                ST_FAULT: begin
                    if (is_q1) begin
                        st_n  = ST_ACQUIRE;
                        trk_n = 1'b1;
                        acq_n = '0;
                    end
                end
                default: begin
                    st_n  = ST_ACQUIRE;
                    acq_n = '0;
                    trk_n = 1'b0;
                end
            endcase
        end
        locked_n = (st_n == ST_LOCKED);
    end

    // State and output registers; mclr overrides everything.
    always_ff @(posedge clk) begin
        if (mclr) begin
            state        <= ST_ACQUIRE;
            acq_cnt      <= '0;
            trk          <= 1'b0;
            phase        <= PH_Q1;
            locked       <= 1'b0;
            cycle_strobe <= 1'b0;
            instr_q      <= 16'd0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            err_count    <= 8'd0;
        end else begin
            state        <= st_n;
            acq_cnt      <= acq_n;
            trk          <= trk_n;
            phase        <= ph_n;
            locked       <= locked_n;
            cycle_strobe <= strobe_n;
            instr_q      <= instr_n;
            err          <= err_n;
            err_code     <= code_n;
            err_count    <= cnt_n;
        end
    end

endmodule

// File: tb/tb_pic16f84_qphase_decoder.sv
// Directed self-checking bench for pic16f84_qphase_decoder.
// Each task drives one scenario and compares against hand values.
module tb_pic16f84_qphase_decoder;

    logic        clk = 1'b0;
    logic        mclr;
    logic [3:0]  vdd;
    logic [3:0]  vss;
    logic        q1, q2, q3, q4;
    logic        clk_out;
    logic [1:0]  phase;
    logic        locked;
    logic        cycle_strobe;
    logic [15:0] instr_count;
    logic        err;
    logic [2:0]  err_code;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    pic16f84_qphase_decoder dut (
        .clk          (clk),
        .mclr         (mclr),
        .vdd          (vdd),
        .vss          (vss),
        .q1           (q1),
        .q2           (q2),
        .q3           (q3),
        .q4           (q4),
        .clk_out      (clk_out),
        .phase        (phase),
        .locked       (locked),
        .cycle_strobe (cycle_strobe),
        .instr_count  (instr_count),
        .err          (err),
        .err_code     (err_code),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] q, input logic co);
        {q4, q3, q2, q1} = q;
        clk_out = co;
        @(posedge clk);
        #1;
    endtask

    task automatic ideal(input int p);
        logic [3:0] oh;
        oh = 4'b0001;
        drive(oh << p, (p < 2));
    endtask

    task automatic relock();
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 4; p++)
                ideal(p);
    endtask

    task automatic test_reset();
        mclr = 1'b1;
        vdd = 4'h5;
        vss = 4'h0;
        drive(4'b0001, 1'b1);
        drive(4'b0001, 1'b1);
        checks++;
        if (locked !== 1'b0 || phase !== 2'd0 || cycle_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: locked=%b phase=%0d strobe=%b want 0/0/0",
                     locked, phase, cycle_strobe);
        end
        checks++;
        if (instr_count !== 16'd0 || err !== 1'b0 ||
            err_code !== 3'd0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counts: instr=%0d err=%b code=%0d cnt=%0d want zeros",
                     instr_count, err, err_code, err_count);
        end
        mclr = 1'b0;
    endtask

    task automatic test_lock();
        int n;
        ideal(0);
        ideal(1);
        ideal(3);
        checks++;
        if (err !== 1'b0 || err_count !== 8'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL acq_deviation: err=%b cnt=%0d locked=%b want 0/0/0",
                     err, err_count, locked);
        end
        for (int p = 0; p < 4; p++) ideal(p);
        for (int p = 0; p < 3; p++) ideal(p);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: locked=%b want 0", locked);
        end
        ideal(3);
        checks++;
        if (locked !== 1'b1 || cycle_strobe !== 1'b0 || phase !== 2'd3) begin
            errors++;
            $display("FAIL lock_2nd_q4: locked=%b strobe=%b phase=%0d want 1/0/3",
                     locked, cycle_strobe, phase);
        end
        n = 0;
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 4; p++) begin
                ideal(p);
                if (cycle_strobe === 1'b1) n++;
                checks++;
                if (cycle_strobe !== (p == 3) || phase !== 2'(p)) begin
                    errors++;
                    $display("FAIL strobe_phase: p=%0d strobe=%b phase=%0d",
                             p, cycle_strobe, phase);
                end
            end
        end
        checks++;
        if (n != 3 || instr_count !== 16'd3) begin
            errors++;
            $display("FAIL instr_count: strobes=%0d instr=%0d want 3/3",
                     n, instr_count);
        end
    endtask

    task automatic test_order();
        ideal(0);
        ideal(2);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd2 ||
            err_count !== 8'd1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL order_fault: err=%b code=%0d cnt=%0d locked=%b want 1/2/1/0",
                     err, err_code, err_count, locked);
        end
        ideal(3);
        checks++;
        if (err !== 1'b0 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL order_pulse: err=%b cnt=%0d want 0/1", err, err_count);
        end
        for (int p = 0; p < 4; p++) ideal(p);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL order_relock_early: locked=%b want 0", locked);
        end
        for (int p = 0; p < 4; p++) ideal(p);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL order_relock: locked=%b want 1", locked);
        end
    endtask

    task automatic test_priority();
        ideal(0);
        drive(4'b0011, 1'b1);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd1 || err_count !== 8'd2) begin
            errors++;
            $display("FAIL onehot_fault: err=%b code=%0d cnt=%0d want 1/1/2",
                     err, err_code, err_count);
        end
        relock();
        ideal(0);
        ideal(1);
        drive(4'b0100, 1'b1);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd3 ||
            err_count !== 8'd3 || locked !== 1'b0) begin
            errors++;
            $display("FAIL clkout_fault: err=%b code=%0d cnt=%0d locked=%b want 1/3/3/0",
                     err, err_code, err_count, locked);
        end
        relock();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL prio_relock: locked=%b want 1", locked);
        end
    endtask

    task automatic test_power();
        int any_lock;
        vdd = 4'h3;
        ideal(0);
        checks++;
        if (err !== 1'b1 || err_code !== 3'd4 ||
            err_count !== 8'd4 || locked !== 1'b0) begin
            errors++;
            $display("FAIL pwr_fault: err=%b code=%0d cnt=%0d locked=%b want 1/4/4/0",
                     err, err_code, err_count, locked);
        end
        ideal(1);
        checks++;
        if (err !== 1'b0 || err_count !== 8'd4) begin
            errors++;
            $display("FAIL pwr_hold: err=%b cnt=%0d want 0/4", err, err_count);
        end
        vdd = 4'h5;
        ideal(2);
        ideal(3);
        relock();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL pwr_relock: locked=%b want 1", locked);
        end
        vss = 4'h1;
        any_lock = 0;
        for (int c = 0; c < 3; c++)
            for (int p = 0; p < 4; p++) begin
                ideal(p);
                if (locked !== 1'b0) any_lock++;
            end
        checks++;
        if (any_lock != 0 || err_code !== 3'd4 || err_count !== 8'd5) begin
            errors++;
            $display("FAIL vss_fail: lockcnt=%0d code=%0d cnt=%0d want 0/4/5",
                     any_lock, err_code, err_count);
        end
        vss = 4'h0;
        relock();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL vss_relock: locked=%b want 1", locked);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            ideal(0);
            ideal(2);
            if (i == 249) begin
                checks++;
                if (err_count !== 8'hFF) begin
                    errors++;
                    $display("FAIL sat_reach: cnt=%0d want 255", err_count);
                end
            end
            relock();
        end
        checks++;
        if (err_count !== 8'hFF || err_code !== 3'd2 || locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: cnt=%0d code=%0d locked=%b want 255/2/1",
                     err_count, err_code, locked);
        end
    endtask

    task automatic test_wrap();
        dut.instr_q = 16'hFFFF;
        ideal(0);
        ideal(1);
        ideal(2);
        checks++;
        if (instr_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_pre: instr=%h want ffff", instr_count);
        end
        ideal(3);
        checks++;
        if (instr_count !== 16'h0000 || cycle_strobe !== 1'b1) begin
            errors++;
            $display("FAIL wrap: instr=%h strobe=%b want 0000/1",
                     instr_count, cycle_strobe);
        end
    endtask

    task automatic test_back_to_back_mclr();
        for (int p = 0; p < 4; p++) ideal(p);
        ideal(0);
        checks++;
        if (instr_count !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL pre_mclr: instr=%0d locked=%b want 1/1",
                     instr_count, locked);
        end
        mclr = 1'b1;
        drive(4'b1000, 1'b0);
        checks++;
        if (cycle_strobe !== 1'b0 || err !== 1'b0 || locked !== 1'b0 ||
            instr_count !== 16'd0 || err_code !== 3'd0 ||
            err_count !== 8'd0 || phase !== 2'd0) begin
            errors++;
            $display("FAIL mclr_prio: strobe=%b err=%b locked=%b instr=%0d code=%0d cnt=%0d phase=%0d",
                     cycle_strobe, err, locked, instr_count,
                     err_code, err_count, phase);
        end
        mclr = 1'b0;
    endtask

    initial begin
        {q4, q3, q2, q1} = 4'b0000;
        clk_out = 1'b0;
        mclr = 1'b1;
        vdd = 4'h5;
        vss = 4'h0;
        test_reset();
        test_lock();
        test_order();
        test_priority();
        test_power();
        test_saturate();
        test_wrap();
        test_back_to_back_mclr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pic16f84_qphase_decoder.md
PIC16F84_QPHASE_DECODER -- requirements
Module: pic16f84_qphase_decoder

Interface
REQ-001 Parameter LOCK_CYCLES, default 2: number of consecutive error-free instruction cycles (Q1..Q4) required to assert locked.
REQ-002 Parameter VDD_MIN, default 4'h4: minimum vdd code treated as power-good.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 mclr  input  1  reset, synchronous, active-high.
REQ-005 vdd  input  4  supply code; vdd < VDD_MIN or vss != 0 is power-fail.
REQ-006 vss  input  4  ground code.
REQ-007 q1, q2, q3, q4  input  1 each  quadrature phase lines from the clock generator; exactly one is expected high per clk cycle.
REQ-008 clk_out  input  1  OSC/4 line; expected high during Q1,Q2 and low during Q3,Q4.
REQ-009 phase  output  2  decoded current phase (0=Q1 .. 3=Q4), valid when locked.
REQ-010 locked  output  1  phase sequence acquired and error-free.
REQ-011 cycle_strobe  output  1  one-clk pulse when a Q4 is accepted while locked.
REQ-012 instr_count  output  16  accepted instruction cycles while locked; wraps 16'hFFFF -> 0.
REQ-013 err  output  1  one-clk pulse on any detected fault.
REQ-014 err_code  output  3  cause of the most recent fault; held until the next fault or reset.
REQ-015 err_count  output  8  fault count; saturates at 8'hFF.

Function
REQ-016 Inputs are sampled on each rising clk edge; all outputs are registered and reflect that sample after the same edge (1-cycle latency).
REQ-017 Decode: one-hot {q4,q3,q2,q1} maps to phase 0..3; zero-hot or multi-hot is a ONEHOT fault (err_code 3'd1).
REQ-018 State machine has three states: ACQUIRE, LOCKED, FAULT.
REQ-019 ACQUIRE: waits for a valid Q1, then tracks the sequence Q1->Q2->Q3->Q4->Q1; a deviation restarts the search without asserting err; after LOCK_CYCLES complete cycles ending in Q4 -> LOCKED.
REQ-020 LOCKED: each sample must equal expected phase (previous+1 mod 4), else ORDER fault (3'd2); clk_out must match REQ-008, else CLKOUT fault (3'd3); a ONEHOT fault has priority over ORDER, and ORDER over CLKOUT.
REQ-021 On any fault in LOCKED: err=1 for one cycle, err_code updated, err_count incremented (saturating), locked=0 on the same edge, state -> FAULT.
REQ-022 FAULT: exits to ACQUIRE on the first valid Q1 sample, which counts as the start of the first acquisition cycle.
REQ-023 Power-fail in any state: state -> ACQUIRE, locked=0, err pulse with err_code 3'd4 only when leaving LOCKED; acquisition progress is cleared while power-fail persists.
REQ-024 cycle_strobe and instr_count increment occur on the same edge; neither occurs on a faulted Q4.
REQ-025 Faults are not flagged in ACQUIRE or FAULT; err_count counts only faults raised from LOCKED or power-fail from LOCKED.

Reset
REQ-026 mclr=1 at a rising edge: state=ACQUIRE, phase=0, locked=0, cycle_strobe=0, instr_count=0, err=0, err_code=0, err_count=0, acquisition counter=0.
REQ-027 mclr has priority over all other events, including a simultaneous fault or Q4.

Structure
REQ-028 Shared package pic16f84_pkg holds the phase encoding, the state enumeration, the err_code constants (NONE=0, ONEHOT=1, ORDER=2, CLKOUT=3, PWR=4) and the expected clk_out-per-phase table.
REQ-029 One sub-module, pic16f84_q_encode: combinational {q4..q1} -> {valid, phase[1:0]}.

Verification
REQ-030 Ideal Q1..Q4 stream at 1 phase/clk, clk_out per REQ-008, mclr released -> locked=1 after the 2nd Q4; then cycle_strobe once per 4 clks and instr_count=3 after 5 cycles.
REQ-031 While locked, inject q3 in place of q2 -> err=1 for one clk, err_code=2, err_count=1, locked=0; resume at next Q1 -> locked again after 2 cycles.
REQ-032 While locked, drive q1=q2=1 for one clk -> err_code=1 (ONEHOT wins over ORDER); clk_out inverted at Q3 only -> err_code=3.
REQ-033 While locked, drop vdd to 4'h3 -> err_code=4, locked=0; restore vdd=4'h5 -> relock after 2 cycles; keep vss=4'h1 -> never locks.
REQ-034 Preload 300 ORDER faults -> err_count=8'hFF; preload instr_count=16'hFFFF, one more Q4 -> 0.
REQ-035 Assert mclr on the same edge as a Q4 and an ORDER fault -> all outputs at reset values, no cycle_strobe, no err.
